// File: rtl/calc_result_unit_if.sv
// -----------------------------------------------------------------------------
// calc_result_unit_if
// Bus between the calculator control FSM / switches and the result unit.
//
// Signal semantics (one place, for the whole bus):
//   - Din/WE/W1 form an operand write. A write lands on a rising clock edge
//     where WE=1 and the unit is not busy; W1 picks opB (1) or opA (0).
//   - Done_in is a level. Its rising edge requests one compute of the
//     operation on MS_in. The request is taken only when the unit is idle.
//     Holding Done_in high keeps the finished result on display. Dropping it
//     ends the display, or aborts a compute that is still running.
//   - valid=1 means bcd/neg/err/ovf are final and stable. busy=1 means a
//     compute or conversion is running; operand writes are dropped then.
//
// Ports (master = FSM side, slave = result unit):
//   Din[DW]  WE  W1  MS_in[4]  Done_in        master -> slave
//   bcd[4*NDIG]  neg  err  ovf  busy  valid   slave  -> master
// -----------------------------------------------------------------------------
interface calc_result_unit_if #(
    parameter int DW   = 8,
    parameter int NDIG = 4
);
    logic [DW-1:0]     Din;
    logic              WE;
    logic              W1;
    logic [3:0]        MS_in;
    logic              Done_in;
    logic [4*NDIG-1:0] bcd;
    logic              neg;
    logic              err;
    logic              ovf;
    logic              busy;
    logic              valid;

    modport master (
        output Din, WE, W1, MS_in, Done_in,
        input  bcd, neg, err, ovf, busy, valid
    );

    modport slave (
        input  Din, WE, W1, MS_in, Done_in,
        output bcd, neg, err, ovf, busy, valid
    );
endinterface

// File: rtl/calc_result_unit.sv
// -----------------------------------------------------------------------------
// calc_result_unit
// Datapath stage that sits after the calculator control FSM. It captures two
// unsigned operands and computes ADD/SUB/MUL/DIV/MOD/AND/OR/XOR. MUL and
// DIV/MOD take one step per cycle. The binary result is converted to NDIG BCD
// digits by a sequential double-dabble, and those digits feed the LED mux.
//
// Ports:
//   CLK        system clock, rising edge
//   clear      asynchronous active-low reset
//   bus        calc_result_unit_if slave modport (operands, op, Done, results)
//   state_dbg  current FSM state, for observation only
// -----------------------------------------------------------------------------
module calc_result_unit #(
    parameter int DW   = 8,
    parameter int NDIG = 4
) (
    input  logic              CLK,
    input  logic              clear,
    calc_result_unit_if.slave bus,
    output logic [2:0]        state_dbg
);
    localparam int RW = 2 * DW;
    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(RW) + 1;
    localparam logic [CW-1:0] ITER_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(RW - 1);
    localparam logic [RW-1:0] DISP_MAX  = RW'(10**NDIG - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_ITER = 3'd2,
        S_CONV = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] acc_q, acc_d;       // product (MUL) or partial remainder (DIV/MOD)
    logic [DW-1:0] work_q, work_d;     // multiplier bits (MUL) or quotient (DIV/MOD)
    logic [RW-1:0] result_q, result_d; // binary result, consumed MSB-first by CONV
    logic [BW-1:0] bcd_acc_q, bcd_acc_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic          neg_q, neg_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;

    logic             start;
    logic [RW-1:0]    prod_nxt;
    logic [DW:0]      rem_shift, rem_nxt;
    logic [DW-1:0]    quo_nxt;
    logic [BW-1:0]    adj;
    logic [BW+RW-1:0] shift_v;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        work_d    = work_q;
        result_d  = result_q;
        bcd_acc_d = bcd_acc_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        done_d    = bus.Done_in;
        start     = bus.Done_in & ~done_q;

        // One shift-add step: multiplier consumed MSB first.
        prod_nxt = {acc_q[RW-2:0], 1'b0} + (work_q[DW-1] ? RW'(opa_q) : '0);

        // One restoring-division step: dividend bits enter MSB first via work_q.
        rem_shift = {acc_q[DW-1:0], work_q[DW-1]};
        quo_nxt   = {work_q[DW-2:0], 1'b0};
        rem_nxt   = rem_shift;
        if (rem_shift >= {1'b0, opb_q}) begin
            rem_nxt    = rem_shift - {1'b0, opb_q};
            quo_nxt[0] = 1'b1;
        end

        // Double-dabble: add 3 to every digit >= 5, then shift the pair left.
        adj = bcd_acc_q;
        for (int i = 0; i < NDIG; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        shift_v = {adj, result_q} << 1;

        if (bus.WE && !busy_q) begin
            if (bus.W1) opb_d = bus.Din;
            else        opa_d = bus.Din;
        end

        if (!bus.Done_in && (state_q == S_EXEC || state_q == S_ITER || state_q == S_CONV)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_EXEC;
                        op_d    = bus.MS_in;
                    end
                end
                S_EXEC: begin
                    neg_d     = 1'b0;
                    err_d     = 1'b0;
                    ovf_d     = 1'b0;
                    cnt_d     = '0;
                    bcd_acc_d = '0;
                    state_d   = S_CONV;
                    case (op_q)
                        OP_ADD: result_d = RW'(opa_q) + RW'(opb_q);
                        OP_SUB: begin
                            if (opa_q < opb_q) begin
                                neg_d    = 1'b1;
                                result_d = RW'(opb_q - opa_q);
                            end else begin
                                result_d = RW'(opa_q - opb_q);
                            end
                        end
                        OP_MUL: begin
                            acc_d   = '0;
                            work_d  = opb_q;
                            state_d = S_ITER;
                        end
                        OP_DIV, OP_MOD: begin
                            if (opb_q == '0) begin
                                err_d   = 1'b1;
                                bcd_d   = '1;
                                state_d = S_HOLD;
                            end else begin
                                acc_d   = '0;
                                work_d  = opa_q;
                                state_d = S_ITER;
                            end
                        end
                        OP_AND:  result_d = RW'(opa_q & opb_q);
                        OP_OR:   result_d = RW'(opa_q | opb_q);
                        OP_XOR:  result_d = RW'(opa_q ^ opb_q);
                        default: result_d = '0;
                    endcase
                end
                S_ITER: begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q == OP_MUL) begin
                        acc_d  = prod_nxt;
                        work_d = work_q << 1;
                    end else begin
                        acc_d  = RW'(rem_nxt);
                        work_d = quo_nxt;
                    end
                    if (cnt_q == ITER_LAST) begin
                        cnt_d     = '0;
                        bcd_acc_d = '0;
                        state_d   = S_CONV;
                        if (op_q == OP_MUL)      result_d = prod_nxt;
                        else if (op_q == OP_DIV) result_d = RW'(quo_nxt);
                        else                     result_d = RW'(rem_nxt);
                    end
                end
                S_CONV: begin
                    if (cnt_q == '0 && result_q > DISP_MAX) begin
                        ovf_d   = 1'b1;
                        bcd_d   = '1;
                        state_d = S_HOLD;
                    end else begin
                        bcd_acc_d = shift_v[BW+RW-1:RW];
                        result_d  = shift_v[RW-1:0];
                        cnt_d     = cnt_q + 1'b1;
                        if (cnt_q == CONV_LAST) begin
                            bcd_d   = shift_v[BW+RW-1:RW];
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!bus.Done_in) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d  = (state_d == S_EXEC) || (state_d == S_ITER) || (state_d == S_CONV);
        valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge CLK or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            result_q  <= '0;
            bcd_acc_q <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            work_q    <= work_d;
            result_q  <= result_d;
            bcd_acc_q <= bcd_acc_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign bus.bcd   = bcd_q;
    assign bus.neg   = neg_q;
    assign bus.err   = err_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_calc_result_unit.sv
module tb_calc_result_unit;
    logic       CLK;
    logic       clear;
    logic [2:0] state_dbg;

    calc_result_unit_if #(.DW(8), .NDIG(4)) bus();

    calc_result_unit #(.DW(8), .NDIG(4)) dut (
        .CLK       (CLK),
        .clear     (clear),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [18:0] exp_q[$];   // {bcd[15:0], neg, err, ovf}

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [18:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int r;
        logic n, e, o;
        logic [15:0] d;
        r = 0; n = 1'b0; e = 1'b0; o = 1'b0;
        case (op)
            4'd0: r = int'(a) + int'(b);
            4'd1: begin
                if (a < b) begin n = 1'b1; r = int'(b) - int'(a); end
                else r = int'(a) - int'(b);
            end
            4'd2: r = int'(a) * int'(b);
            4'd3: if (b == 8'd0) e = 1'b1; else r = int'(a) / int'(b);
            4'd4: if (b == 8'd0) e = 1'b1; else r = int'(a) % int'(b);
            4'd5: r = int'(a & b);
            4'd6: r = int'(a | b);
            4'd7: r = int'(a ^ b);
            default: r = 0;
        endcase
        if (e) d = 16'hFFFF;
        else if (r > 9999) begin o = 1'b1; d = 16'hFFFF; end
        else d = {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
        return {d, n, e, o};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic write_operands(input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK); bus.WE = 1'b1; bus.W1 = 1'b0; bus.Din = a;
        @(negedge CLK); bus.W1 = 1'b1; bus.Din = b;
        @(negedge CLK); bus.WE = 1'b0; bus.W1 = 1'b0; bus.Din = 8'h00;
    endtask

    // Raise Done_in and wait for valid; lat = edges after the start-sampling edge.
    task automatic do_run(input logic [3:0] op, output int lat, output logic [18:0] obs);
        @(negedge CLK); bus.MS_in = op; bus.Done_in = 1'b1;
        lat = -1;
        obs = '0;
        for (int i = 0; i < 60 && lat < 0; i++) begin
            @(negedge CLK);
            if (bus.valid === 1'b1) begin
                lat = i;
                obs = {bus.bcd, bus.neg, bus.err, bus.ovf};
            end
        end
    endtask

    task automatic end_run();
        @(negedge CLK); bus.Done_in = 1'b0;
        @(negedge CLK);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (bus.bcd !== 16'h0000) begin
            n_fail++; $display("FAIL reset_bcd: got %h want 0000", bus.bcd);
        end
        n_checks++;
        if ({bus.neg, bus.err, bus.ovf, bus.busy, bus.valid} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags: got neg/err/ovf/busy/valid=%b want 00000",
                     {bus.neg, bus.err, bus.ovf, bus.busy, bus.valid});
        end
        clear = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_directed();
        logic [7:0]  ta [6];
        logic [7:0]  tb [6];
        logic [3:0]  top [6];
        logic [15:0] tbcd [6];
        logic [2:0]  tfl [6];
        int lat;
        logic [18:0] obs, exp_v;
        logic lat_ok;
        ta   = '{8'd200, 8'd5, 8'd255, 8'd99, 8'd7, 8'd200};
        tb   = '{8'd100, 8'd9, 8'd255, 8'd99, 8'd0, 8'd7};
        top  = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4};
        tbcd = '{16'h0300, 16'h0004, 16'hFFFF, 16'h9801, 16'hFFFF, 16'h0004};
        tfl  = '{3'b000, 3'b100, 3'b001, 3'b000, 3'b010, 3'b000};
        for (int i = 0; i < 6; i++) begin
            write_operands(ta[i], tb[i]);
            exp_q.push_back({tbcd[i], tfl[i]});
            do_run(top[i], lat, obs);
            exp_v = exp_q.pop_front();
            if (tfl[i][1])      lat_ok = (lat >= 1 && lat <= 3);
            else if (tfl[i][0]) lat_ok = (lat >= 1 && lat < 25);
            else                lat_ok = (lat == ((top[i] >= 4'd2 && top[i] <= 4'd4) ? 25 : 17));
            n_checks++;
            if (!lat_ok) begin
                n_fail++; $display("FAIL directed_latency[%0d]: got %0d edges (op %0d)", i, lat, top[i]);
            end
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got bcd=%h n/e/o=%b want bcd=%h n/e/o=%b",
                         i, obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
            end
            end_run();
            n_checks++;
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_release[%0d]: got valid=%b busy=%b want 0 0", i, bus.valid, bus.busy);
            end
        end
    endtask

    task automatic test_busy_write();
        int lat;
        logic [18:0] obs;
        write_operands(8'd12, 8'd34);
        @(negedge CLK); bus.MS_in = 4'd2; bus.Done_in = 1'b1;
        lat = -1; obs = '0;
        for (int i = 0; i < 60 && lat < 0; i++) begin
            @(negedge CLK);
            if (bus.valid === 1'b1) begin
                lat = i; obs = {bus.bcd, bus.neg, bus.err, bus.ovf};
            end
            if (i == 4) begin bus.WE = 1'b1; bus.W1 = 1'b0; bus.Din = 8'h33; end
            if (i == 5) begin bus.WE = 1'b0; bus.Din = 8'h00; end
        end
        n_checks++;
        if (lat != 25) begin
            n_fail++; $display("FAIL busy_write_latency: got %0d want 25", lat);
        end
        n_checks++;
        if (obs !== {16'h0408, 3'b000}) begin
            n_fail++; $display("FAIL busy_write_mul: got %h/%b want 0408/000", obs[18:3], obs[2:0]);
        end
        end_run();
        // Rerun without rewriting: operands must still be 12 and 34.
        do_run(4'd0, lat, obs);
        n_checks++;
        if (lat != 17) begin
            n_fail++; $display("FAIL busy_write_add_latency: got %0d want 17", lat);
        end
        n_checks++;
        if (obs !== {16'h0046, 3'b000}) begin
            n_fail++; $display("FAIL busy_write_opa_kept: got %h/%b want 0046/000", obs[18:3], obs[2:0]);
        end
        end_run();
    endtask

    task automatic test_abort();
        int lat;
        logic [18:0] obs;
        logic saw_valid;
        write_operands(8'd40, 8'd2);
        @(negedge CLK); bus.MS_in = 4'd0; bus.Done_in = 1'b1;
        repeat (6) @(negedge CLK);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_busy_before: got %b want 1", bus.busy);
        end
        bus.Done_in = 1'b0;
        saw_valid = 1'b0;
        repeat (25) begin
            @(negedge CLK);
            if (bus.valid !== 1'b0) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_valid: got valid pulse after abort, want none");
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy_after: got %b want 0", bus.busy);
        end
        do_run(4'd0, lat, obs);
        n_checks++;
        if (lat != 17 || obs !== {16'h0042, 3'b000}) begin
            n_fail++; $display("FAIL abort_rerun: got lat=%0d %h/%b want 17 0042/000", lat, obs[18:3], obs[2:0]);
        end
        end_run();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a, b;
        logic [3:0]  op;
        int lat, want_lat;
        logic [18:0] obs, exp_v;
        logic lat_ok;
        for (int k = 0; k < 24; k++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            op = 4'($urandom_range(0, 15));
            if ((op == 4'd3 || op == 4'd4) && $urandom_range(0, 3) == 0) b = 8'd0;
            write_operands(a, b);
            exp_q.push_back(model(a, b, op));
            do_run(op, lat, obs);
            exp_v = exp_q.pop_front();
            want_lat = (op >= 4'd2 && op <= 4'd4) ? 25 : 17;
            if (exp_v[1])      lat_ok = (lat >= 1 && lat <= 3);
            else if (exp_v[0]) lat_ok = (lat >= 1 && lat < 25);
            else               lat_ok = (lat == want_lat);
            n_checks++;
            if (!lat_ok) begin
                n_fail++; $display("FAIL rand_latency[%0d]: got %0d op=%0d a=%0d b=%0d", k, lat, op, a, b);
            end
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: op=%0d a=%0d b=%0d got %h/%b want %h/%b",
                         k, op, a, b, obs[18:3], obs[2:0], exp_v[18:3], exp_v[2:0]);
            end
            end_run();
            n_checks++;
            if (bus.valid !== 1'b0) begin
                n_fail++; $display("FAIL rand_release[%0d]: got valid=%b want 0", k, bus.valid);
            end
        end
    endtask

    task automatic test_async_reset();
        int lat;
        logic [18:0] obs;
        write_operands(8'd250, 8'd3);
        @(negedge CLK); bus.MS_in = 4'd2; bus.Done_in = 1'b1;
        repeat (4) @(negedge CLK);
        #2 clear = 1'b0;
        #1;
        n_checks++;
        if ({bus.bcd, bus.neg, bus.err, bus.ovf, bus.busy, bus.valid} !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got bcd=%h n/e/o/b/v=%b want all 0",
                     bus.bcd, {bus.neg, bus.err, bus.ovf, bus.busy, bus.valid});
        end
        @(negedge CLK); bus.Done_in = 1'b0;
        @(negedge CLK); clear = 1'b1;
        // Operands were reset to 0, so MUL must give 0.
        do_run(4'd2, lat, obs);
        n_checks++;
        if (lat != 25) begin
            n_fail++; $display("FAIL async_reset_rerun_latency: got %0d want 25", lat);
        end
        n_checks++;
        if (obs !== {16'h0000, 3'b000}) begin
            n_fail++; $display("FAIL async_reset_operands: got %h/%b want 0000/000", obs[18:3], obs[2:0]);
        end
        end_run();
        write_operands(8'd77, 8'd23);
        do_run(4'd0, lat, obs);
        n_checks++;
        if (lat != 17 || obs !== {16'h0100, 3'b000}) begin
            n_fail++; $display("FAIL async_reset_normal: got lat=%0d %h/%b want 17 0100/000", lat, obs[18:3], obs[2:0]);
        end
        end_run();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        clear       = 1'b0;
        bus.Din     = 8'h00;
        bus.WE      = 1'b0;
        bus.W1      = 1'b0;
        bus.MS_in   = 4'd0;
        bus.Done_in = 1'b0;
        test_reset();
        test_directed();
        test_busy_write();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
